// File: rtl/dither_gen_if.sv
// Signal bundle for dither_gen: measurement controls in, dither/result/state out.
// Master drives the controls (stimulus side); slave is the dither_gen core.
interface dither_gen_if;
  logic               i_trig;
  logic [2:0]         i_avg_sel;
  logic signed [31:0] i_data;
  logic [31:0]        i_wait_cnt;
  logic signed [31:0] o_dither_out;
  logic signed [31:0] o_data;
  logic [3:0]         o_cstate;
  logic [3:0]         o_nstate;

  modport master (
    output i_trig, i_avg_sel, i_data, i_wait_cnt,
    input  o_dither_out, o_data, o_cstate, o_nstate
  );

  modport slave (
    input  i_trig, i_avg_sel, i_data, i_wait_cnt,
    output o_dither_out, o_data, o_cstate, o_nstate
  );
endinterface

// File: rtl/dither_gen.sv
// Dither generator / synchronous demodulator: alternates +1/-1 dither per measurement,
// averages 2^avg_sel samples per phase, outputs H-L. Macro DITHER_GEN_DEBUG_PORTS_EN adds debug outputs.
module dither_gen (
  input  logic               i_clk,
  input  logic               i_rst,
  dither_gen_if.slave        bus
`ifdef DITHER_GEN_DEBUG_PORTS_EN
  ,
  output logic signed [31:0] o_reg_data_H,
  output logic signed [31:0] o_reg_data_L,
  output logic signed [31:0] o_reg_sum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WAIT   = 4'd1,
    S_ACC    = 4'd2,
    S_STORE  = 4'd3,
    S_OUTPUT = 4'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        cnt_q;
  logic [31:0]        wait_q;
  logic [2:0]         sel_q;
  logic [7:0]         n_last;
  logic signed [31:0] acc_q;
  logic signed [31:0] reg_h_q;
  logic signed [31:0] reg_l_q;
  logic signed [31:0] data_q;
  logic signed [31:0] dither_q;

  // Last sample index of the ACC phase for the held averaging select.
  always_comb begin
    n_last = 8'((9'd1 << sel_q) - 9'd1);
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (bus.i_trig) begin
          state_d = (bus.i_wait_cnt == 32'd0) ? S_ACC : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT:   state_d = (cnt_q == wait_q - 32'd1) ? S_ACC : S_WAIT;
      S_ACC:    state_d = (cnt_q == {24'd0, n_last}) ? S_STORE : S_ACC;
      S_STORE:  state_d = S_OUTPUT;
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      wait_q   <= 32'd0;
      sel_q    <= 3'd0;
      acc_q    <= 32'sd0;
      reg_h_q  <= 32'sd0;
      reg_l_q  <= 32'sd0;
      data_q   <= 32'sd0;
      dither_q <= 32'sd1;
    end else begin
      state_q <= state_d;
      // Phase counter restarts on every state change so WAIT and ACC both count from zero.
      if ((state_d != state_q) || (state_q == S_IDLE)) begin
        cnt_q <= 32'd0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.i_trig) begin
            sel_q  <= bus.i_avg_sel;
            wait_q <= bus.i_wait_cnt;
            acc_q  <= 32'sd0;
          end
        end
        S_ACC: begin
          acc_q <= acc_q + bus.i_data;
        end
        S_STORE: begin
          if (dither_q == 32'sd1) begin
            reg_h_q <= acc_q >>> sel_q;
          end else begin
            reg_l_q <= acc_q >>> sel_q;
          end
        end
        S_OUTPUT: begin
          data_q   <= reg_h_q - reg_l_q;
          dither_q <= -dither_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_dither_out = dither_q;
  assign bus.o_data       = data_q;
  assign bus.o_cstate     = state_q;
  assign bus.o_nstate     = state_d;

`ifdef DITHER_GEN_DEBUG_PORTS_EN
  assign o_reg_data_H = reg_h_q;
  assign o_reg_data_L = reg_l_q;
  assign o_reg_sum    = acc_q;
`endif

endmodule

// File: tb/tb_dither_gen.sv
// Bench for dither_gen: directed scenarios with literal checks plus randomized traffic
// compared every cycle against a schedule-queue model of the measurement sequence.
module tb_dither_gen;

  logic clk;
  logic rst;
  dither_gen_if bus();

`ifdef DITHER_GEN_DEBUG_PORTS_EN
  logic signed [31:0] dbg_h;
  logic signed [31:0] dbg_l;
  logic signed [31:0] dbg_sum;
  dither_gen dut (.i_clk(clk), .i_rst(rst), .bus(bus),
                  .o_reg_data_H(dbg_h), .o_reg_data_L(dbg_l), .o_reg_sum(dbg_sum));
`else
  dither_gen dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A trigger in IDLE expands into the full list of upcoming states; each edge pops one.
  int                 m_cur;
  int                 m_q[$];
  logic [2:0]         m_sel;
  logic signed [31:0] m_sum, m_h, m_l, m_data, m_dith;

  always @(posedge clk) begin
    if (rst) begin
      m_cur = 0; m_q.delete(); m_sel = 3'd0;
      m_sum = 0; m_h = 0; m_l = 0; m_data = 0; m_dith = 1;
    end else begin
      case (m_cur)
        0: if (bus.i_trig) begin
          m_sel = bus.i_avg_sel;
          m_sum = 0;
          m_q.delete();
          for (int i = 0; i < int'(bus.i_wait_cnt); i++) m_q.push_back(1);
          for (int i = 0; i < (1 << bus.i_avg_sel); i++) m_q.push_back(2);
          m_q.push_back(3);
          m_q.push_back(4);
        end
        2: m_sum = m_sum + bus.i_data;
        3: if (m_dith == 1) m_h = m_sum >>> m_sel; else m_l = m_sum >>> m_sel;
        4: begin m_data = m_h - m_l; m_dith = -m_dith; end
        default: ;
      endcase
      m_cur = (m_q.size() > 0) ? m_q.pop_front() : 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int exp_n;
    if (chk_en) begin
      chk("cstate", {28'd0, bus.o_cstate}, 32'(m_cur));
      chk("dither", bus.o_dither_out, m_dith);
      chk("data", bus.o_data, m_data);
      if (!rst) begin
        if (m_q.size() > 0) exp_n = m_q[0];
        else if (m_cur == 0 && bus.i_trig) exp_n = (bus.i_wait_cnt == 0) ? 2 : 1;
        else exp_n = 0;
        chk("nstate", {28'd0, bus.o_nstate}, 32'(exp_n));
      end
`ifdef DITHER_GEN_DEBUG_PORTS_EN
      chk("reg_h", dbg_h, m_h);
      chk("reg_l", dbg_l, m_l);
      chk("reg_sum", dbg_sum, m_sum);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.i_trig = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; bus.i_trig = 1'b0; bus.i_avg_sel = 3'd0; bus.i_data = 32'sd0; bus.i_wait_cnt = 32'd0;
    do_reset();
    chk("rst_cstate", {28'd0, bus.o_cstate}, 32'd0);
    chk("rst_dither", bus.o_dither_out, 32'h00000001);
    chk("rst_data", bus.o_data, 32'd0);

    // Shortest measurement: IDLE, ACC, STORE, OUTPUT, IDLE.
    bus.i_trig = 1'b1; bus.i_wait_cnt = 0; bus.i_avg_sel = 0; bus.i_data = 7;
    cyc(); bus.i_trig = 1'b0;
    chk("t_acc", {28'd0, bus.o_cstate}, 32'd2);
    cyc(); chk("t_store", {28'd0, bus.o_cstate}, 32'd3);
    cyc(); chk("t_output", {28'd0, bus.o_cstate}, 32'd4);
    cyc(); chk("t_idle", {28'd0, bus.o_cstate}, 32'd0);
    chk("t_data", bus.o_data, 32'd7);
    chk("t_dither", bus.o_dither_out, 32'hFFFFFFFF);

    // Basic demodulation, i_data follows the dither polarity.
    do_reset();
    bus.i_avg_sel = 4; bus.i_wait_cnt = 9;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 101; k++) begin
        bus.i_trig = (k == 0);
        bus.i_data = (bus.o_dither_out == 1) ? 32'sd1000 : -32'sd2100;
        cyc();
        if (k == 40) begin
          if (m == 0) begin
            chk("demod_h_model", m_h, 32'd1000);
            chk("demod1_dither", bus.o_dither_out, 32'hFFFFFFFF);
            chk("demod1_data", bus.o_data, 32'd1000);
          end else if (m == 1) begin
            chk("demod_l_model", m_l, -32'sd2100);
            chk("demod2_dither", bus.o_dither_out, 32'h00000001);
            chk("demod2_data", bus.o_data, 32'd3100);
          end else begin
            chk("demodn_data", bus.o_data, 32'd3100);
          end
        end
      end
    end
    bus.i_trig = 1'b0;

    // Trigger while busy in ACC is dropped.
    do_reset();
    bus.i_avg_sel = 3; bus.i_wait_cnt = 2; bus.i_data = 5;
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0;
    run(3);
    chk("busy_in_acc", {28'd0, bus.o_cstate}, 32'd2);
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0;
    run(20);
    chk("busy_dither", bus.o_dither_out, 32'hFFFFFFFF);
    chk("busy_data", bus.o_data, 32'd5);

    // Reset during ACC discards the partial measurement.
    do_reset();
    bus.i_avg_sel = 0; bus.i_wait_cnt = 0; bus.i_data = 10;
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0; run(5);
    bus.i_avg_sel = 2; bus.i_data = 100;
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_cstate", {28'd0, bus.o_cstate}, 32'd0);
    chk("mid_rst_dither", bus.o_dither_out, 32'h00000001);
    chk("mid_rst_data", bus.o_data, 32'd0);
    bus.i_avg_sel = 1; bus.i_wait_cnt = 1; bus.i_data = 20;
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0; run(10);
    chk("after_rst_h", bus.o_data, 32'd20);

    // Arithmetic shift keeps negative averages negative.
    do_reset();
    bus.i_avg_sel = 7; bus.i_wait_cnt = 0; bus.i_data = -32'sd3;
    bus.i_trig = 1'b1; cyc(); bus.i_trig = 1'b0; run(140);
    chk("ashift_data", bus.o_data, 32'hFFFFFFFD);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.i_trig     = ($urandom_range(0, 3) == 0);
      bus.i_avg_sel  = 3'($urandom_range(0, 4));
      bus.i_wait_cnt = $urandom_range(0, 5);
      bus.i_data     = $urandom;
      rst            = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; bus.i_trig = 1'b0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
